uart_serial_line_tx: RTL

//  Synthesizable UART serial transmitter that drives the SIN line of the UART under test.
//  It is the transmit-side counterpart of the bench's receive-side line checking.

---
 rtl/uart_serial_line_tx.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/uart_serial_line_tx.sv
// UART serial transmitter with a small byte FIFO and 16x divisor timing.
// Drives a line with 5-8 data bits, optional/stick parity, 1/1.5/2 stop bits and break.
module uart_serial_line_tx #(
  parameter int PDATA_WIDTH = 8,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          PCLK,
  input  logic                          PRESET,
  input  logic [15:0]                   divisor,
  input  logic [6:0]                    lcr,
  input  logic [PDATA_WIDTH-1:0]        tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          tx_busy,
  output logic                          char_done,
  output logic                          SOUT
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;

  state_t state, state_nx;

  logic [PDATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [AW:0]            count;

  logic [PDATA_WIDTH-1:0] data_q, mask;
  logic [5:0]             lcr_q;
  logic [15:0]            div_q, tick;
  logic [4:0]             samp, samp_last;
  logic [2:0]             bit_idx, bit_idx_nx, last_bit;
  logic                   push, pop, start_ok;
  logic                   tick_end, bit_end;
  logic                   par_bit, line_nx, sout_q;

  assign tx_ready   = count != (AW+1)'(FIFO_DEPTH);
  assign fifo_count = count;
  assign SOUT       = sout_q;

  assign push     = tx_valid && tx_ready;
  assign start_ok = (count != '0) && (divisor != 16'd0);
  assign pop      = start_ok &&
                    (state == IDLE || (state == STOP && bit_end));

  assign tick_end = tick == div_q - 16'd1;
  assign last_bit = 3'd4 + {1'b0, lcr_q[1:0]};
  assign mask     = {PDATA_WIDTH{1'b1}} >> (2'd3 - lcr_q[1:0]);

  // 1.5 stop bits only for 5-bit words, otherwise STB means 2
  always_comb begin
    samp_last = 5'd15;
    if (state == STOP && lcr_q[2])
      samp_last = (lcr_q[1:0] == 2'b00) ? 5'd23 : 5'd31;
  end

  assign bit_end = (state != IDLE) && tick_end && (samp == samp_last);

  assign par_bit = lcr_q[5] ? ~lcr_q[4]
                            : (^(data_q & mask)) ^ ~lcr_q[4];

  always_ff @(posedge PCLK) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start_ok) state_nx = START;
      START:   if (bit_end) state_nx = DATA;
      DATA:
        if (bit_end && bit_idx == last_bit)
          state_nx = lcr_q[3] ? PARITY : STOP;
      PARITY:  if (bit_end) state_nx = STOP;
      STOP:
        if (bit_end) state_nx = start_ok ? START : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // line_nx is the level for the cycle after this edge
  always_comb begin
    bit_idx_nx = 3'd0;
    if (state == DATA)
      bit_idx_nx = bit_end ? bit_idx + 3'd1 : bit_idx;
    line_nx = 1'b1;
    unique case (state_nx)
      START:   line_nx = 1'b0;
      DATA:    line_nx = data_q[bit_idx_nx];
      PARITY:  line_nx = par_bit;
      default: line_nx = 1'b1;
    endcase
    tx_busy   = state != IDLE;
    char_done = (state == STOP) && bit_end;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      tick    <= '0;
      samp    <= '0;
      bit_idx <= '0;
      data_q  <= '0;
      lcr_q   <= '0;
      div_q   <= '0;
      sout_q  <= 1'b1;
    end else begin
      bit_idx <= bit_idx_nx;
      sout_q  <= ~lcr[6] & line_nx;
      if (pop) begin
        data_q <= mem[rd_ptr];
        lcr_q  <= lcr[5:0];
        div_q  <= divisor;
      end
      if (pop || state == IDLE) begin
        tick <= '0;
        samp <= '0;
      end else if (tick_end) begin
        tick <= '0;
        samp <= bit_end ? 5'd0 : samp + 5'd1;
      end else begin
        tick <= tick + 16'd1;
      end
    end
  end

endmodule
